// File: rtl/sim_dmem_pkg.sv
// Shared definitions for the sim_dmem data memory: state encoding,
// lane-count derivation and an elaboration-time parameter legality check.
`ifndef SIM_DMEM_PKG_SV
`define SIM_DMEM_PKG_SV

// Expands to a generate block that aborts elaboration on an illegal
// parameter combination (lane split, depth range, read latency range).
`define SIM_DMEM_CHECK_PARAMS(DW, LW, DEPTH, AW, RL) \
    if ((((DW) % (LW)) != 0) || ((DEPTH) < 1) || ((DEPTH) > (1 << (AW))) || \
        ((RL) < 1) || ((RL) > 4)) begin : g_bad_params \
        $error("sim_dmem: illegal parameter combination"); \
    end

package sim_dmem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Number of independently maskable lanes in one word.
    function automatic int lanes_of(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

endpackage

`endif

// File: rtl/sim_dmem_rd_pipe.sv
// Read response delay line: READ_LATENCY stages of valid/data/err that
// advance only when en is high. Data and err load only alongside a valid
// entry, so the tail stage holds the last response between reads.
module sim_dmem_rd_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_err,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err
);

    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
        logic                  valid_q, valid_d;
        logic                  err_q, err_d;
        logic [DATA_WIDTH-1:0] data_q, data_d;
        logic                  prev_valid;
        logic                  prev_err;
        logic [DATA_WIDTH-1:0] prev_data;

        if (gi == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_err   = in_err;
            assign prev_data  = in_data;
        end else begin : g_link
            assign prev_valid = g_stage[gi-1].valid_q;
            assign prev_err   = g_stage[gi-1].err_q;
            assign prev_data  = g_stage[gi-1].data_q;
        end

        // Shift one slot per enabled edge; payload only moves with a valid entry.
        always_comb begin
            valid_d = valid_q;
            err_d   = err_q;
            data_d  = data_q;
            if (en) begin
                valid_d = prev_valid;
                if (prev_valid) begin
                    err_d  = prev_err;
                    data_d = prev_data;
                end
            end
        end

        // Stage register; reset flushes any in-flight response.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q <= 1'b0;
                err_q   <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                err_q   <= err_d;
                data_q  <= data_d;
            end
        end
    end

    assign out_valid = g_stage[READ_LATENCY-1].valid_q;
    assign out_data  = g_stage[READ_LATENCY-1].data_q;
    assign out_err   = g_stage[READ_LATENCY-1].err_q;

endmodule

// File: rtl/sim_dmem_pipe.sv
// Synthesizable data memory with valid/ready requests, per-lane write masks,
// configurable read latency, post-reset zero-clear and out-of-range flagging.
module sim_dmem_pipe
    import sim_dmem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 13,
    parameter int DATA_WIDTH   = 32,
    parameter int LANE_WIDTH   = 8,
    parameter int DEPTH        = 8192,
    parameter int READ_LATENCY = 1,
    parameter int INIT_CLEAR   = 1,
    localparam int LANES       = lanes_of(DATA_WIDTH, LANE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  write_en,
    input  logic [LANES-1:0]      write_mask,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  resp_err,
    output logic                  busy
);

    `SIM_DMEM_CHECK_PARAMS(DATA_WIDTH, LANE_WIDTH, DEPTH, ADDR_WIDTH, READ_LATENCY)

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  accept;
    logic                  addr_in_range;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  clear_wr;
    logic [DATA_WIDTH-1:0] rd_word;

    // req_ready is gated by rst so nothing looks acceptable while reset is held.
    assign req_ready     = rst && (state_q == ST_RUN);
    assign busy          = (state_q == ST_CLEAR);
    assign accept        = req_valid && req_ready && clk_en;
    // One extra bit so DEPTH == 2**ADDR_WIDTH compares correctly.
    assign addr_in_range = ({1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH));
    assign rd_accept     = accept && !write_en;
    assign wr_accept     = accept && write_en && addr_in_range;
    assign clear_wr      = rst && clk_en && (state_q == ST_CLEAR);
    // Out-of-range reads return zero rather than whatever aliases in the array.
    assign rd_word       = addr_in_range ? mem_q[addr] : '0;

    // Clear sequencer: walk clr_cnt over every word, then hand over to RUN.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (clk_en && (state_q == ST_CLEAR)) begin
            if (clr_cnt_q == LAST_WORD) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end
    end

    // State and clear counter; reset restarts the clear from word 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Memory array write port (no reset): clear writes zero, requests write masked lanes.
    always_ff @(posedge clk) begin
        if (clear_wr) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (write_mask[i]) begin
                    mem_q[addr][i*LANE_WIDTH +: LANE_WIDTH] <= write_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    sim_dmem_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (clk_en),
        .in_valid  (rd_accept),
        .in_data   (rd_word),
        .in_err    (!addr_in_range),
        .out_valid (resp_valid),
        .out_data  (read_data),
        .out_err   (resp_err)
    );

endmodule

// File: tb/tb_sim_dmem_pipe.sv
// Directed bench for sim_dmem_pipe with a small 12-word, latency-3 instance.
module tb_sim_dmem_pipe;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int LW    = 8;
    localparam int DEPTH = 12;
    localparam int RL    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] addr;
    logic          write_en;
    logic [3:0]    write_mask;
    logic [DW-1:0] write_data;
    logic          resp_valid;
    logic [DW-1:0] read_data;
    logic          resp_err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    int            rd_n;
    logic [AW-1:0] rd_addr [16];
    logic [DW-1:0] rd_exp  [16];
    logic          rd_err  [16];

    always #5 clk = ~clk;

    sim_dmem_pipe #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .LANE_WIDTH   (LW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL),
        .INIT_CLEAR   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .addr       (addr),
        .write_en   (write_en),
        .write_mask (write_mask),
        .write_data (write_data),
        .resp_valid (resp_valid),
        .read_data  (read_data),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
        req_valid  = 1'b1;
        write_en   = 1'b1;
        addr       = a;
        write_data = d;
        write_mask = m;
        tick();
        req_valid  = 1'b0;
        write_en   = 1'b0;
        check("write_no_resp", resp_valid, 1'b0);
        $display("write addr=%0d data=%08h mask=%b", a, d, m);
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a, input logic [DW-1:0] e, input logic er);
        rd_addr[i] = a;
        rd_exp[i]  = e;
        rd_err[i]  = er;
    endtask

    // Back-to-back reads; response k is expected RL-1 ticks after accept k.
    task automatic run_reads(input string tag);
        for (int c = 0; c < rd_n + RL; c++) begin
            int k;
            if (c < rd_n) begin
                req_valid = 1'b1;
                write_en  = 1'b0;
                addr      = rd_addr[c];
            end else begin
                req_valid = 1'b0;
            end
            tick();
            k = c - (RL - 1);
            if (k >= 0 && k < rd_n) begin
                check({tag, "_valid"}, resp_valid, 1'b1);
                check({tag, "_data"}, read_data, rd_exp[k]);
                check({tag, "_err"}, resp_err, rd_err[k]);
                $display("read %s addr=%0d data=%08h err=%0b", tag, rd_addr[k], read_data, resp_err);
            end else begin
                check({tag, "_idle"}, resp_valid, 1'b0);
            end
        end
        req_valid = 1'b0;
    endtask

    // Count edges until busy falls (bounded), watching for stray responses.
    task automatic wait_clear(input string tag);
        int n;
        logic saw;
        n   = 0;
        saw = 1'b0;
        do begin
            tick();
            n++;
            if (resp_valid !== 1'b0) saw = 1'b1;
        end while (busy === 1'b1 && n < 40);
        req_valid = 1'b0;
        check({tag, "_edges"}, n, 12);
        check({tag, "_ready"}, req_ready, 1'b1);
        check({tag, "_no_resp"}, saw, 1'b0);
        $display("clear %s finished after %0d edges", tag, n);
    endtask

    initial begin
        rst        = 1'b1;
        clk_en     = 1'b1;
        req_valid  = 1'b0;
        write_en   = 1'b0;
        addr       = '0;
        write_mask = '0;
        write_data = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_read_data", read_data, 32'h0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_busy", busy, 1'b1);
        $display("reset state checked");
        tick();
        tick();
        rst = 1'b1;
        wait_clear("init");

        // All words read back as zero after the clear.
        rd_n = DEPTH;
        for (int i = 0; i < DEPTH; i++) set_rd(i, AW'(i), 32'h0, 1'b0);
        run_reads("cleared");

        // Masked writes, read-after-write, all-zero mask.
        wr(4'd3, 32'hAABBCCDD, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd_n = 1;
        set_rd(0, 4'd3, 32'hAA22CC44, 1'b0);
        run_reads("masked");
        wr(4'd3, 32'hFFFFFFFF, 4'b0000);
        run_reads("mask_zero");

        // Latency and ordering of back-to-back reads.
        wr(4'd0, 32'd0, 4'hF);
        wr(4'd1, 32'd1, 4'hF);
        wr(4'd2, 32'd2, 4'hF);
        wr(4'd3, 32'd3, 4'hF);
        rd_n = 4;
        for (int i = 0; i < 4; i++) set_rd(i, AW'(i), DW'(i), 1'b0);
        run_reads("latency");

        // Stall: a read accepted, then clk_en low with a write offered.
        wr(4'd5, 32'h55, 4'hF);
        req_valid = 1'b1;
        write_en  = 1'b0;
        addr      = 4'd5;
        tick();
        check("stall_e1", resp_valid, 1'b0);
        clk_en     = 1'b0;
        write_en   = 1'b1;
        addr       = 4'd6;
        write_data = 32'h66;
        write_mask = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_frozen", resp_valid, 1'b0);
        end
        clk_en    = 1'b1;
        req_valid = 1'b0;
        write_en  = 1'b0;
        tick();
        check("stall_e2", resp_valid, 1'b0);
        tick();
        check("stall_e3_valid", resp_valid, 1'b1);
        check("stall_e3_data", read_data, 32'h55);
        check("stall_e3_err", resp_err, 1'b0);
        $display("read stall addr=5 data=%08h", read_data);
        clk_en = 1'b0;
        tick();
        check("stall_hold_valid1", resp_valid, 1'b1);
        tick();
        check("stall_hold_valid2", resp_valid, 1'b1);
        clk_en = 1'b1;
        tick();
        check("stall_pulse_end", resp_valid, 1'b0);
        check("stall_data_hold", read_data, 32'h55);
        rd_n = 1;
        set_rd(0, 4'd6, 32'h0, 1'b0);
        run_reads("stall_write_dropped");

        // Out-of-range write and reads.
        wr(4'd13, 32'hFFFFFFFF, 4'hF);
        rd_n = 3;
        set_rd(0, 4'd1, 32'd1, 1'b0);
        set_rd(1, 4'd13, 32'h0, 1'b1);
        set_rd(2, 4'd11, 32'h0, 1'b0);
        run_reads("range");

        // Reset with one response visible and two more in flight.
        req_valid = 1'b1;
        write_en  = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            addr = AW'(i);
            tick();
        end
        req_valid = 1'b0;
        check("inflight_valid", resp_valid, 1'b1);
        check("inflight_data", read_data, 32'd1);
        rst = 1'b0;
        #1;
        check("inflight_rst_valid", resp_valid, 1'b0);
        check("inflight_rst_data", read_data, 32'h0);
        check("inflight_rst_busy", busy, 1'b1);
        check("inflight_rst_ready", req_ready, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        wait_clear("after_inflight");

        // Reset in the middle of a clear at clr_cnt = 7; requests offered meanwhile.
        wr(4'd0, 32'hDEADBEEF, 4'hF);
        wr(4'd11, 32'h12345678, 4'hF);
        rst = 1'b0;
        #1;
        tick();
        rst       = 1'b1;
        req_valid = 1'b1;
        write_en  = 1'b0;
        addr      = 4'd0;
        for (int i = 0; i < 7; i++) tick();
        check("midclear_busy", busy, 1'b1);
        check("midclear_ready", req_ready, 1'b0);
        check("midclear_no_resp", resp_valid, 1'b0);
        rst = 1'b0;
        #1;
        check("midclear_rst_busy", busy, 1'b1);
        tick();
        rst = 1'b1;
        wait_clear("restart");
        rd_n = 2;
        set_rd(0, 4'd0, 32'h0, 1'b0);
        set_rd(1, 4'd11, 32'h0, 1'b0);
        run_reads("recleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sim_dmem_pipe.md
Name: sim_dmem_pipe

Overview:
- Synthesizable, parametrised data memory that succeeds the CXXRTL simulation data-memory blackbox.
- Sits behind the TileLink ECC adapter as backing store. Runs in both the CXXRTL sim build and FPGA builds, with no C++ model needed.
- Adds four things over the previous block: a valid/ready request handshake, per-lane write masks, a configurable read latency, and a post-reset zero-clear sequencer.
- Also adds out-of-range error reporting.

Parameters:
- ADDR_WIDTH, 13: word-address width.
- DATA_WIDTH, 32: word width. Must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8: write-mask granularity in bits. LANES = DATA_WIDTH/LANE_WIDTH.
- DEPTH, 8192: number of implemented words. Must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1: cycles from accepted read to resp_valid. Legal range 1..4.
- INIT_CLEAR, 1: 1 = zero every word after reset before accepting requests.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset: asynchronous, active-low (0 = reset asserted).
- clk_en  input  1  global enable; 0 freezes all state, including the clear counter and the read pipeline.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- addr  input  ADDR_WIDTH  word address.
- write_en  input  1  1 = write, 0 = read.
- write_mask  input  LANES  per-lane write enable.
- write_data  input  DATA_WIDTH  write data.
- resp_valid  output  1  one-cycle pulse: read data valid.
- read_data  output  DATA_WIDTH  read result; holds its value between responses.
- resp_err  output  1  qualified by resp_valid: address >= DEPTH.
- busy  output  1  clear sequence in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - outputs go to resp_valid=0, read_data=0, resp_err=0, req_ready=0;
  - read pipeline is flushed;
  - busy=1 if INIT_CLEAR else 0;
  - memory array contents are not reset.
- State machine has two states, CLEAR and RUN.
  - Leaving reset enters CLEAR when INIT_CLEAR=1, otherwise RUN.
  - CLEAR: each cycle with clk_en=1, write zero to word clr_cnt and increment clr_cnt from 0. Moving to RUN happens on the edge that writes word DEPTH-1.
  - In CLEAR, busy=1 and req_ready=0. Requests are ignored and are not buffered.
  - RUN: busy=0 and req_ready=1. No backpressure.
- Accept condition: req_valid & req_ready & clk_en at a rising edge.
- Write handling:
  - A write updates lane i only if write_mask[i]=1. A mask of all zeros leaves memory unchanged.
  - A write produces no response.
  - A write to an address >= DEPTH is dropped silently.
- Read handling:
  - The array is read at the accept edge.
  - resp_valid is high for exactly one clk_en-qualified cycle, READ_LATENCY edges after accept.
  - read_data updates in the same cycle and holds afterwards.
  - Back-to-back reads give back-to-back responses in order; throughput is 1 per cycle.
  - A read of an address >= DEPTH returns read_data=0 and resp_err=1.
- Read after write to the same address on consecutive accepts returns the new data.
- clk_en=0 stalls everything:
  - nothing is accepted;
  - the pipeline does not advance;
  - resp_valid keeps its current value;
  - clr_cnt holds.
- Reset in the middle of a clear or with reads in flight: in-flight responses are lost and never emitted. The clear restarts at word 0.

Decomposition:
- Shared package/header sim_dmem_pkg holds:
  - the state encoding (ST_CLEAR=0, ST_RUN=1);
  - the LANES derivation function;
  - a parameter-legality check macro for DATA_WIDTH%LANE_WIDTH==0, DEPTH range and READ_LATENCY range.
- One sub-module, sim_dmem_rd_pipe: a READ_LATENCY-deep valid/data/err shift register with enable and async active-low flush.

Test Plan:
- Clear sequence: DEPTH=16, INIT_CLEAR=1, release rst at cycle 0 with clk_en=1.
  - busy stays 1 for exactly 16 edges, then req_ready=1.
  - Reads of words 0..15 all return 0x00000000.
- Masked write: write 0xAABBCCDD to addr 3 with mask 4'b1111, then write 0x11223344 with mask 4'b0101.
  - A read of addr 3 returns 0xAA22CC44 with resp_err=0.
- Read latency: READ_LATENCY=3, four back-to-back reads of addr 0..3 holding 0,1,2,3.
  - resp_valid is high on cycles 3,4,5,6 after the first accept.
  - read_data sequence is 0,1,2,3.
- Stall: READ_LATENCY=2; issue a read of addr 5 (data 0x55), then hold clk_en=0 for 4 cycles after the first edge.
  - resp_valid appears only after two enabled edges in total; data is 0x55.
  - No requests are accepted during the stall.
- Out of range: DEPTH=12, ADDR_WIDTH=4.
  - Write 0xFFFFFFFF to addr 13 is dropped.
  - A read of addr 13 gives resp_err=1 and read_data=0.
  - A read of addr 11 gives resp_err=0.
- Reset mid-operation: assert rst during the clear at clr_cnt=7, and separately with two reads in flight.
  - resp_valid drops immediately and stale responses never appear.
  - busy=1 and the clear restarts from word 0.
